// File: rtl/seq101_pkg.sv
// Shared definitions for the seq101 serial pattern family: FSM encoding and default pattern.
package seq101_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } gen_state_t;

    localparam logic [2:0] DEFAULT_PAT = 3'b101;

endpackage

// File: rtl/seq101_gen_if.sv
// Request/stream bundle between a pattern requester and seq101_gen.
interface seq101_gen_if #(
    parameter int PAT_W = 3,
    parameter int RPT_W = 8
);
    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [RPT_W-1:0] repeat_cnt;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern_in, repeat_cnt,
        input  seq_out, seq_valid, busy, done
    );

    modport slave (
        input  start, pattern_in, repeat_cnt,
        output seq_out, seq_valid, busy, done
    );
endinterface

// File: rtl/seq101_gen_shreg.sv
// Loadable left-shift register with bit-down-counter; exposes the MSB it will hold next cycle.
module seq101_gen_shreg #(
    parameter int PAT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb_next,
    output logic             cnt_zero
);
    localparam int CW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PAT_W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [PAT_W-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = din;
            cnt_d  = CNT_MAX;
        end else if (shift) begin
            data_d = {data_q[PAT_W-2:0], 1'b0};
            cnt_d  = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // Registered outputs in the top need the bit that will be on the wire next cycle.
    assign msb_next = data_d[PAT_W-1];
    assign cnt_zero = (cnt_q == '0);
endmodule

// File: rtl/seq101_gen.sv
// Serial "101"-family pattern transmitter: FSM plus repeat/gap counters around a shift register.
// Optional SEQ101_GEN_GAP_EN inserts GAP_LEN idle cycles between consecutive repeats.
module seq101_gen
    import seq101_pkg::*;
#(
    parameter int PAT_W   = 3,
    parameter int RPT_W   = 8,
    parameter int GAP_LEN = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    seq101_gen_if.slave  bus
);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

    if (PAT_W < 2 || GAP_LEN < 1) begin : g_bad_param
        $error("seq101_gen: PAT_W must be >= 2 and GAP_LEN >= 1");
    end

    gen_state_t       state_q, state_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] load_din;
    logic             load, shift, accept;
    logic             msb_next, cnt_zero;

`ifdef SEQ101_GEN_GAP_EN
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_LEN - 1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);
    logic [GW-1:0] gap_q, gap_d;
`endif

    assign accept = (state_q == IDLE) && bus.start;

    seq101_gen_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .shift    (shift),
        .din      (load_din),
        .msb_next (msb_next),
        .cnt_zero (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        rpt_d    = rpt_q;
        load     = 1'b0;
        shift    = 1'b0;
        load_din = pat_q;
`ifdef SEQ101_GEN_GAP_EN
        gap_d    = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    load_din = bus.pattern_in;
                    rpt_d    = (bus.repeat_cnt == '0) ? RPT_ONE : bus.repeat_cnt;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!cnt_zero) begin
                    shift = 1'b1;
                end else begin
                    rpt_d = rpt_q - RPT_ONE;
                    if (rpt_q > RPT_ONE) begin
                        load = 1'b1;
`ifdef SEQ101_GEN_GAP_EN
                        gap_d   = GAP_MAX;
                        state_d = GAP;
`else
                        state_d = SHIFT;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
`ifdef SEQ101_GEN_GAP_EN
            GAP: begin
                if (gap_q == '0) state_d = SHIFT;
                else             gap_d   = gap_q - GAP_ONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rpt_q   <= '0;
            pat_q   <= PAT_W'(DEFAULT_PAT);
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            if (accept) pat_q <= bus.pattern_in;
        end
    end

`ifdef SEQ101_GEN_GAP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) gap_q <= '0;
        else          gap_q <= gap_d;
    end
`endif

    // Outputs decode the next state so the first bit appears the cycle after start is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.seq_out   <= 1'b0;
            bus.seq_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.seq_out   <= (state_d == SHIFT) && msb_next;
            bus.seq_valid <= (state_d == SHIFT);
            bus.busy      <= (state_d == SHIFT) || (state_d == GAP);
            bus.done      <= (state_d == DONE);
        end
    end
endmodule

// File: tb/tb_seq101_gen.sv
// Randomized self-checking bench for seq101_gen against a per-cycle expected stream model.
module tb_seq101_gen;
    localparam int PAT_W   = 3;
    localparam int RPT_W   = 8;
    localparam int GAP_LEN = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   dets;

    seq101_gen_if #(.PAT_W(PAT_W), .RPT_W(RPT_W)) bus ();

    seq101_gen #(.PAT_W(PAT_W), .RPT_W(RPT_W), .GAP_LEN(GAP_LEN)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".seq_out"},   bus.seq_out,   0);
        chk({tag, ".seq_valid"}, bus.seq_valid, 0);
        chk({tag, ".busy"},      bus.busy,      0);
        chk({tag, ".done"},      bus.done,      0);
    endtask

    // Entered and left at #1 after a rising edge. Expected stream built from the pattern/repeat rules.
    task automatic run_txn(input logic [PAT_W-1:0] pat, input logic [RPT_W-1:0] rpt,
                           input bit glitch, output int ndet);
        bit   ev[$];
        bit   eo[$];
        int   n;
        logic [2:0] hist;
        int   nbits;
        n     = (rpt == 0) ? 1 : int'(rpt);
        ndet  = 0;
        hist  = '0;
        nbits = 0;
        for (int r = 0; r < n; r++) begin
            for (int k = PAT_W - 1; k >= 0; k--) begin
                ev.push_back(1'b1);
                eo.push_back(pat[k]);
            end
`ifdef SEQ101_GEN_GAP_EN
            if (r < n - 1)
                for (int g = 0; g < GAP_LEN; g++) begin
                    ev.push_back(1'b0);
                    eo.push_back(1'b0);
                end
`endif
        end
        bus.start      = 1'b1;
        bus.pattern_in = pat;
        bus.repeat_cnt = rpt;
        @(posedge clock); #1;
        bus.start      = 1'b0;
        bus.pattern_in = PAT_W'($urandom);
        bus.repeat_cnt = RPT_W'($urandom);
        for (int i = 0; i < ev.size(); i++) begin
            chk($sformatf("c%0d.seq_valid", i + 1), bus.seq_valid, ev[i]);
            chk($sformatf("c%0d.seq_out", i + 1),   bus.seq_out,   eo[i]);
            chk($sformatf("c%0d.busy", i + 1),      bus.busy,      1);
            chk($sformatf("c%0d.done", i + 1),      bus.done,      0);
            if (bus.seq_valid === 1'b1) begin
                hist = {hist[1:0], bus.seq_out};
                nbits++;
                if (nbits >= 3 && hist == 3'b101) ndet++;
            end
            if (glitch) begin
                bus.start      = ($urandom_range(0, 1) == 1);
                bus.pattern_in = PAT_W'($urandom);
                bus.repeat_cnt = RPT_W'($urandom);
            end
            @(posedge clock); #1;
        end
        bus.start = 1'b0;
        chk($sformatf("c%0d.done_pulse", ev.size() + 1), bus.done, 1);
        chk("done_cycle.busy",      bus.busy,      0);
        chk("done_cycle.seq_valid", bus.seq_valid, 0);
        chk("done_cycle.seq_out",   bus.seq_out,   0);
        @(posedge clock); #1;
        chk_idle("after_done");
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pattern_in = '0;
        bus.repeat_cnt = '0;
        #1;
        chk_idle("reset");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        chk_idle("post_reset");

        run_txn(3'b101, 8'd1, 1'b0, dets);
        run_txn(3'b101, 8'd3, 1'b0, dets);
        chk("loopback_101_count", dets, 3);
        run_txn(3'b110, 8'd2, 1'b0, dets);
        run_txn(3'b011, 8'd1, 1'b1, dets);
        run_txn(3'b111, 8'd0, 1'b0, dets);
        run_txn(3'b000, 8'd0, 1'b1, dets);

        // Abort mid-stream: asynchronous clear, no done pulse, then a clean restart.
        bus.start      = 1'b1;
        bus.pattern_in = 3'b101;
        bus.repeat_cnt = 8'd1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk("abort.c1.seq_valid", bus.seq_valid, 1);
        @(posedge clock); #1;
        chk("abort.c2.busy", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_idle("abort.async");
        @(posedge clock); #1;
        chk_idle("abort.held");
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        chk_idle("abort.released");
        run_txn(3'b101, 8'd1, 1'b0, dets);

        for (int t = 0; t < 25; t++) begin
            run_txn(PAT_W'($urandom), RPT_W'($urandom_range(0, 6)),
                    ($urandom_range(0, 1) == 1), dets);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
                chk_idle("idle_gap");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
